// File: rtl/pdm_audio_core.sv
// pdm_audio_core
// PDM microphone recorder with an on-chip sample buffer and PWM playback.
// The mic clock is divided down from clk; on every mic_clk rising edge
// ("tick") one PDM bit is counted while recording, or one PWM slot is
// produced while playing back. DECIM bits form one unsigned sample 0..DECIM,
// and each stored sample is replayed as one PWM period of DECIM ticks.
//
// Ports:
//   i_clk, i_reset        system clock, synchronous active-high reset
//   i_record_btn          rising edge starts a recording (ignored unless idle)
//   i_playback_btn        rising edge starts playback of the stored samples
//   i_stop_btn            level, aborts recording or playback
//   i_loop_en             1 = playback wraps to sample 0 after the last one
//   i_mic_data_pdm        PDM bit from the microphone
//   o_mic_clk             generated mic clock
//   o_mic_lrsel           mic channel select (constant LR_SEL)
//   o_aud_data_pwm        PWM audio output
//   o_aud_en              amplifier enable, high only while playing
//   o_busy_rec            registered "recording" status
//   o_busy_play           registered "playing" status
//   o_full                last recording filled the whole buffer
//   o_sample_count        number of valid samples in the buffer
module pdm_audio_core #(
    parameter int   MIC_DIV  = 25,
    parameter int   DECIM    = 64,
    parameter int   DEPTH    = 1024,
    parameter logic LR_SEL   = 1'b0,
    localparam int  SAMPLE_W = $clog2(DECIM) + 1,
    localparam int  ADDR_W   = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_record_btn,
    input  logic              i_playback_btn,
    input  logic              i_stop_btn,
    input  logic              i_loop_en,
    input  logic              i_mic_data_pdm,
    output logic              o_mic_clk,
    output logic              o_mic_lrsel,
    output logic              o_aud_data_pwm,
    output logic              o_aud_en,
    output logic              o_busy_rec,
    output logic              o_busy_play,
    output logic              o_full,
    output logic [ADDR_W:0]   o_sample_count
);

    localparam int BIT_W = $clog2(DECIM);
    localparam int DIV_W = (MIC_DIV > 1) ? $clog2(MIC_DIV) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REC, S_PLAY} state_t;

    state_t                r_state;
    logic [DIV_W-1:0]      r_div;
    logic                  r_mic_clk;
    logic                  r_rec_q;
    logic                  r_play_q;
    logic [SAMPLE_W-1:0]   r_acc;
    logic [BIT_W-1:0]      r_bitcnt;
    logic [ADDR_W-1:0]     r_wr_ptr;
    logic [ADDR_W-1:0]     r_rd_ptr;
    logic [BIT_W-1:0]      r_pwm_cnt;
    logic [SAMPLE_W-1:0]   r_sample;
    logic [ADDR_W:0]       r_sample_count;
    logic                  r_full;
    logic                  r_pwm;
    logic                  r_aud_en;
    logic                  r_busy_rec;
    logic                  r_busy_play;
    logic                  r_done;
    logic [SAMPLE_W-1:0]   r_mem [DEPTH];

    logic                  w_tick;
    logic                  w_rec_press;
    logic                  w_play_press;
    logic                  w_win_end;
    logic                  w_pwm_wrap;
    logic                  w_last;
    logic                  w_wr_en;
    logic [SAMPLE_W-1:0]   w_sample_in;
    logic [ADDR_W-1:0]     w_rd_next;

    // tick is the cycle in which mic_clk is about to toggle 0->1
    assign w_tick       = (r_div == DIV_W'(MIC_DIV - 1)) && !r_mic_clk;
    assign w_rec_press  = i_record_btn & ~r_rec_q;
    assign w_play_press = i_playback_btn & ~r_play_q;
    assign w_win_end    = (r_bitcnt == BIT_W'(DECIM - 1));
    assign w_pwm_wrap   = (r_pwm_cnt == BIT_W'(DECIM - 1));
    assign w_last       = (({1'b0, r_rd_ptr} + 1'b1) == r_sample_count);
    assign w_sample_in  = r_acc + SAMPLE_W'(i_mic_data_pdm);
    assign w_rd_next    = r_rd_ptr + 1'b1;
    assign w_wr_en      = (r_state == S_REC) && !i_reset && !i_stop_btn &&
                          w_tick && w_win_end;

    // Buffer contents survive reset; only the write path is gated.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_sample_in;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= S_IDLE;
            r_div          <= '0;
            r_mic_clk      <= 1'b0;
            r_rec_q        <= 1'b0;
            r_play_q       <= 1'b0;
            r_acc          <= '0;
            r_bitcnt       <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_pwm_cnt      <= '0;
            r_sample_count <= '0;
            r_full         <= 1'b0;
            r_pwm          <= 1'b0;
            r_aud_en       <= 1'b0;
            r_busy_rec     <= 1'b0;
            r_busy_play    <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            if (r_div == DIV_W'(MIC_DIV - 1)) begin
                r_div     <= '0;
                r_mic_clk <= ~r_mic_clk;
            end else begin
                r_div <= r_div + 1'b1;
            end
            r_rec_q     <= i_record_btn;
            r_play_q    <= i_playback_btn;
            r_busy_rec  <= (r_state == S_REC);
            r_busy_play <= (r_state == S_PLAY);

            case (r_state)
                S_IDLE: begin
                    r_pwm    <= 1'b0;
                    r_aud_en <= 1'b0;
                    if (w_rec_press) begin
                        r_state        <= S_REC;
                        r_wr_ptr       <= '0;
                        r_acc          <= '0;
                        r_bitcnt       <= '0;
                        r_sample_count <= '0;
                        r_full         <= 1'b0;
                    end else if (w_play_press && (r_sample_count != '0)) begin
                        // first sample is fetched here so it is ready for the first tick
                        r_state   <= S_PLAY;
                        r_rd_ptr  <= '0;
                        r_pwm_cnt <= '0;
                        r_done    <= 1'b0;
                        r_sample  <= r_mem[0];
                        r_aud_en  <= 1'b1;
                    end
                end

                S_REC: begin
                    if (i_stop_btn) begin
                        r_state  <= S_IDLE;
                        r_acc    <= '0;
                        r_bitcnt <= '0;
                    end else if (w_tick) begin
                        if (w_win_end) begin
                            r_wr_ptr       <= r_wr_ptr + 1'b1;
                            r_sample_count <= r_sample_count + 1'b1;
                            r_acc          <= '0;
                            r_bitcnt       <= '0;
                            if (r_wr_ptr == ADDR_W'(DEPTH - 1)) begin
                                r_full         <= 1'b1;
                                r_sample_count <= (ADDR_W + 1)'(DEPTH);
                                r_state        <= S_IDLE;
                            end
                        end else begin
                            r_acc    <= w_sample_in;
                            r_bitcnt <= r_bitcnt + 1'b1;
                        end
                    end
                end

                S_PLAY: begin
                    if (i_stop_btn) begin
                        r_state  <= S_IDLE;
                        r_aud_en <= 1'b0;
                        r_pwm    <= 1'b0;
                    end else if (w_tick) begin
                        if (r_done) begin
                            // last PWM slot has now been shown for a full tick
                            r_state  <= S_IDLE;
                            r_aud_en <= 1'b0;
                            r_pwm    <= 1'b0;
                        end else begin
                            r_pwm     <= ({1'b0, r_pwm_cnt} < r_sample);
                            r_pwm_cnt <= r_pwm_cnt + 1'b1;
                            if (w_pwm_wrap) begin
                                if (w_last) begin
                                    if (i_loop_en) begin
                                        r_rd_ptr <= '0;
                                        r_sample <= r_mem[0];
                                    end else begin
                                        r_done <= 1'b1;
                                    end
                                end else begin
                                    r_rd_ptr <= w_rd_next;
                                    r_sample <= r_mem[w_rd_next];
                                end
                            end
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_mic_clk      = r_mic_clk;
    assign o_mic_lrsel    = LR_SEL;
    assign o_aud_data_pwm = r_pwm;
    assign o_aud_en       = r_aud_en;
    assign o_busy_rec     = r_busy_rec;
    assign o_busy_play    = r_busy_play;
    assign o_full         = r_full;
    assign o_sample_count = r_sample_count;

endmodule
